// File: rtl/btn_sel_toggle_pkg.sv
// Shared definitions for the push-button select conditioner.
// Holds the debounce FSM state encodings and the board default debounce length.
package btn_sel_toggle_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] PWAIT = 2'd1;
    localparam logic [1:0] HELD  = 2'd2;
    localparam logic [1:0] RWAIT = 2'd3;

    // 10 ms at a 100 MHz system clock.
    localparam int unsigned DEB_CYCLES_100MHZ = 1000000;

    function automatic logic is_pressed_state(input logic [1:0] st);
        return (st == HELD) || (st == RWAIT);
    endfunction

endpackage

// File: rtl/btn_sel_toggle_sync.sv
// Reusable two-flop synchroniser for a single asynchronous input bit.
// Both stages clear on a synchronous active-high reset.
module sync_2ff (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);

    logic s1_q;
    logic s2_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            s1_q <= 1'b0;
            s2_q <= 1'b0;
        end else begin
            s1_q <= d;
            s2_q <= s1_q;
        end
    end

    assign q = s2_q;

endmodule

// File: rtl/btn_sel_toggle.sv
// Push-button to mux-select conditioner: synchronise, debounce, toggle sel_out per press.
// All outputs are registered; btn_in reaches them only through the synchroniser.
//
//   state | meaning
//   IDLE  | button released and stable
//   PWAIT | press seen, counting stable-high cycles
//   HELD  | press accepted, button held
//   RWAIT | release seen, counting stable-low cycles
module btn_sel_toggle
    import btn_sel_toggle_pkg::*;
#(
    parameter int unsigned DEB_CYCLES = DEB_CYCLES_100MHZ,
    parameter int unsigned CNT_W      = 20,
    parameter logic        SEL_RST    = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_in,
    output logic sel_out,
    output logic press_pulse,
    output logic btn_stable
);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEB_CYCLES - 1);

    logic             btn_sync;
    logic [1:0]       state_q,  state_d;
    logic [CNT_W-1:0] cnt_q,    cnt_d;
    logic             sel_q,    sel_d;
    logic             pulse_q,  pulse_d;
    logic             stable_q, stable_d;

    sync_2ff u_sync (
        .clk (clk),
        .rst (rst),
        .d   (btn_in),
        .q   (btn_sync)
    );

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        sel_d   = sel_q;
        pulse_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (btn_sync) begin
                    state_d = PWAIT;
                    cnt_d   = '0;
                end
            end
            PWAIT: begin
                if (!btn_sync) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = HELD;
                    cnt_d   = '0;
                    pulse_d = 1'b1;
                    sel_d   = ~sel_q;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            HELD: begin
                if (!btn_sync) begin
                    state_d = RWAIT;
                    cnt_d   = '0;
                end
            end
            RWAIT: begin
                // A high sample here is release bounce; go back without touching sel.
                if (btn_sync) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == CNT_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
        stable_d = is_pressed_state(state_d);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            sel_q    <= SEL_RST;
            pulse_q  <= 1'b0;
            stable_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            sel_q    <= sel_d;
            pulse_q  <= pulse_d;
            stable_q <= stable_d;
        end
    end

    assign sel_out     = sel_q;
    assign press_pulse = pulse_q;
    assign btn_stable  = stable_q;

endmodule
